sensors_scanner: RTL and testbench
==================================

# sensors_scanner

Sequential acquisition front-end that polls the five temperature sensors one at a time over a request/acknowledge handshake. It packs the captured 8-bit readings and per-sensor valid flags into the 40-bit data bus and 5-bit enable mask consumed by the temperature-averaging path. Sensors that fail to answer within a timeout are reported as disabled with zero data. Outputs update atomically once per completed scan.

## Interface
- NR_SENSORS, 5, number of sensors polled; sets the packed bus widths.
- DATA_W, 8, width of one sensor reading.
- TIMEOUT, 15, maximum cycles spent waiting for one sensor's ack; must be ≥ 1.

- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  scan request; sampled only in IDLE.
- sensor_sel_o  output  3  index of the sensor being polled.
- sensor_req_o  output  1  read request to the selected sensor.
- sensor_ack_i  input  1  sensor answer valid; meaningful only while sensor_req_o=1.
- sensor_data_i  input  DATA_W  reading from the selected sensor, valid with sensor_ack_i.
- sensors_data_o  output  NR_SENSORS*DATA_W  packed readings; sensor k at bits [8k+7:8k].
- sensors_en_o  output  NR_SENSORS  bit k=1 when sensor k answered in the last scan.
- scan_done_o  output  1  one-cycle pulse; first cycle in which new sensors_*_o are visible.
- busy_o  output  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, NEXT, DONE.
- IDLE: req=0, busy=0. On start_i=1: idx←0, timer←0, clear shadow data/enable registers, go to WAIT.
- WAIT: sensor_req_o=1, sensor_sel_o=idx.
  - If ack=1: shadow slot idx←sensor_data_i, shadow en[idx]←1, go to NEXT.
  - Otherwise timer increments. When the TIMEOUT-th WAIT cycle ends with no ack: slot←0, en[idx]←0, go to NEXT.
  - An ack on the TIMEOUT-th cycle wins over the timeout.
- NEXT: req=0, so there is always one idle cycle between sensors. If idx=NR_SENSORS-1, go to DONE. Otherwise idx←idx+1, timer←0, go to WAIT.
- DONE: sensors_data_o and sensors_en_o are loaded from the shadow registers on the edge entering DONE. scan_done_o=1 for this cycle only. Next state is IDLE.
- sensors_*_o hold their value between scans. No partial scan result is ever visible.
- Ignored inputs: start_i outside IDLE (including DONE); sensor_ack_i outside WAIT.
- sensor_data_i is not range-checked; any 8-bit value is captured as-is.

## Timing
- Reset values:
  - sensors_data_o=0, sensors_en_o=0, scan_done_o=0, busy_o=0, sensor_req_o=0, sensor_sel_o=0.
  - State=IDLE, idx=0, timer=0, shadow registers=0.
- All outputs are registered and Moore-style (no combinational input→output paths).
- start_i sampled high at edge E0 puts the block in WAIT for sensor 0 from E0; sensor_req_o rises after E0.
- Let w_k be the cycles spent in WAIT for sensor k: (ack delay + 1) when the sensor answers, or TIMEOUT when it does not. Each sensor then costs w_k+1 cycles.
- scan_done_o rises at edge E0 + Σ(w_k+1).
  - All acks immediate: done at E0+10.
  - All timeouts with TIMEOUT=15: done at E0+80.
- The next start_i is accepted at the earliest in the cycle after the scan_done_o pulse, once back in IDLE.
- rst_i mid-scan:
  - Returns to IDLE next edge with all outputs cleared. sensors_*_o are also cleared, not held.
  - No scan_done_o pulse is produced.
  - rst_i has priority over start_i in the same cycle.

## Test plan
- Reset, then start with all sensors acking immediately, data 20,21,22,23,24 → done at E0+10; sensors_data_o=0x1817161514; sensors_en_o=5'b11111; busy_o low in the cycle after done.
- Sensor 2 never acks, others immediate, TIMEOUT=15 → en=5'b11011; bits [23:16]=0; req held 15 cycles for sel=2; done at E0+24.
- Sensor 0 acks on exactly its 15th WAIT cycle → data captured, en[0]=1, no timeout.
- start_i pulsed repeatedly mid-scan and during DONE → ignored; exactly one done pulse. Spurious ack in NEXT/IDLE → no state change.
- Scan A (all 0x30), then scan B (sensor 4 timeout): outputs stay at A until B's done cycle, then switch atomically to en=5'b01111 and top byte=0.
- rst_i asserted while in WAIT for sensor 3 → next cycle: req=0, busy=0, sensors_*_o=0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/sensors_scanner.sv
// Polls NR_SENSORS sensors one at a time over req/ack; a scan costs sum(w_k+1) cycles from start.
// No backpressure: a silent sensor is cut off after TIMEOUT wait cycles and reported disabled.
module sensors_scanner #(
    parameter int NR_SENSORS = 5,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic [2:0]                   sensor_sel_o,
    output logic                         sensor_req_o,
    input  logic                         sensor_ack_i,
    input  logic [DATA_W-1:0]            sensor_data_i,
    output logic [NR_SENSORS*DATA_W-1:0] sensors_data_o,
    output logic [NR_SENSORS-1:0]        sensors_en_o,
    output logic                         scan_done_o,
    output logic                         busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_NEXT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [2:0]                    idx;
    logic [TMR_W-1:0]              timer;
    logic [DATA_W-1:0]             shadow_data [NR_SENSORS];
    logic [NR_SENSORS-1:0]         shadow_en;
    logic [NR_SENSORS*DATA_W-1:0]  data_q;
    logic [NR_SENSORS-1:0]         en_q;
    logic                          timeout;
    logic                          last;

    // Timer counts completed WAIT cycles, so TIMEOUT-1 marks the final allowed cycle.
    assign timeout = (timer == TMR_W'(TIMEOUT - 1));
    assign last    = (idx == 3'(NR_SENSORS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_WAIT;
            ST_WAIT: if (sensor_ack_i || timeout) state_nxt = ST_NEXT;
            ST_NEXT: state_nxt = last ? ST_DONE : ST_WAIT;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sensor_req_o = (state == ST_WAIT);
        busy_o       = (state != ST_IDLE);
        scan_done_o  = (state == ST_DONE);
        sensor_sel_o = idx;
    end

    assign sensors_data_o = data_q;
    assign sensors_en_o   = en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx       <= '0;
            timer     <= '0;
            shadow_en <= '0;
            data_q    <= '0;
            en_q      <= '0;
            for (int k = 0; k < NR_SENSORS; k++) begin
                shadow_data[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        idx       <= '0;
                        timer     <= '0;
                        shadow_en <= '0;
                        for (int k = 0; k < NR_SENSORS; k++) begin
                            shadow_data[k] <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack on the last allowed cycle still counts as an answer.
                    if (sensor_ack_i) begin
                        for (int k = 0; k < NR_SENSORS; k++) begin
                            if (idx == 3'(k)) begin
                                shadow_data[k] <= sensor_data_i;
                                shadow_en[k]   <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        for (int k = 0; k < NR_SENSORS; k++) begin
                            if (idx == 3'(k)) begin
                                shadow_data[k] <= '0;
                                shadow_en[k]   <= 1'b0;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (last) begin
                        // Publish the whole scan in one edge so no partial result is seen.
                        for (int k = 0; k < NR_SENSORS; k++) begin
                            data_q[k*DATA_W +: DATA_W] <= shadow_data[k];
                        end
                        en_q <= shadow_en;
                    end else begin
                        idx   <= idx + 3'd1;
                        timer <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensors_scanner.sv
// Directed and randomized scans of sensors_scanner checked against a per-sensor cost model.
module tb_sensors_scanner;

    localparam int NR  = 5;
    localparam int TMO = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [2:0]    sensor_sel_o;
    logic          sensor_req_o;
    logic          sensor_ack_i;
    logic [7:0]    sensor_data_i;
    logic [39:0]   sensors_data_o;
    logic [4:0]    sensors_en_o;
    logic          scan_done_o;
    logic          busy_o;

    int            total = 0;
    int            bad   = 0;
    int            dly [NR];
    logic [7:0]    val [NR];
    logic [39:0]   last_data = '0;
    logic [4:0]    last_en   = '0;

    sensors_scanner #(.NR_SENSORS(NR), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .sensor_sel_o  (sensor_sel_o),
        .sensor_req_o  (sensor_req_o),
        .sensor_ack_i  (sensor_ack_i),
        .sensor_data_i (sensor_data_i),
        .sensors_data_o(sensors_data_o),
        .sensors_en_o  (sensors_en_o),
        .scan_done_o   (scan_done_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one scan; the sensor responder answers sensor k after dly[k] extra WAIT cycles
    // (negative or >= TIMEOUT means never). Inputs change and outputs are sampled at negedge.
    task automatic run_scan(input bit noise);
        int          exp_n;
        int          w [NR];
        logic [39:0] exp_data;
        logic [4:0]  exp_en;
        int          n;
        int          cnt;
        int          s;
        int          reqcnt [NR];
        bit          done_seen;
        bit          hold_ok;
        bit          prev_req;

        exp_n    = 0;
        exp_data = '0;
        exp_en   = '0;
        for (int k = 0; k < NR; k++) begin
            if (dly[k] >= 0 && dly[k] < TMO) begin
                w[k] = dly[k] + 1;
                exp_data[k*8 +: 8] = val[k];
                exp_en[k] = 1'b1;
            end else begin
                w[k] = TMO;
            end
            exp_n += w[k] + 1;
            reqcnt[k] = 0;
        end

        @(negedge clk_i);
        start_i      = 1'b1;
        sensor_ack_i = 1'b0;
        @(negedge clk_i);
        start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n         = 0;
        cnt       = 0;
        prev_req  = 1'b0;
        done_seen = 1'b0;
        hold_ok   = 1'b1;
        while (n < 300) begin
            if (scan_done_o === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (sensors_data_o !== last_data || sensors_en_o !== last_en) hold_ok = 1'b0;
            if (sensor_req_o === 1'b1) begin
                if (!prev_req) cnt = 0;
                s = int'(sensor_sel_o);
                if (s >= NR) s = 0;
                reqcnt[s]++;
                sensor_ack_i  = (dly[s] >= 0 && cnt == dly[s]);
                sensor_data_i = sensor_ack_i ? val[s] : 8'($urandom);
                cnt++;
            end else begin
                sensor_ack_i  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                sensor_data_i = 8'($urandom);
            end
            prev_req = (sensor_req_o === 1'b1);
            if (noise) start_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            n++;
        end

        chk("done_seen", 64'(done_seen), 64'(1'b1));
        chk("done_cycle", 64'(n), 64'(exp_n));
        chk("data", 64'(sensors_data_o), 64'(exp_data));
        chk("en", 64'(sensors_en_o), 64'(exp_en));
        chk("hold_until_done", 64'(hold_ok), 64'(1'b1));
        for (int k = 0; k < NR; k++) begin
            chk("req_cycles", 64'(reqcnt[k]), 64'(w[k]));
        end

        // start_i and a spurious ack during DONE must both be ignored.
        start_i      = noise;
        sensor_ack_i = noise;
        @(negedge clk_i);
        start_i      = 1'b0;
        sensor_ack_i = 1'b0;
        chk("done_one_cycle", 64'(scan_done_o), 64'(1'b0));
        chk("busy_after_done", 64'(busy_o), 64'(1'b0));
        chk("data_held", 64'(sensors_data_o), 64'(exp_data));
        last_data = exp_data;
        last_en   = exp_en;
    endtask

    initial begin
        bit stray_done;
        int guard;

        rst_i         = 1'b1;
        start_i       = 1'b0;
        sensor_ack_i  = 1'b0;
        sensor_data_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_data", 64'(sensors_data_o), 64'(40'h0));
        chk("rst_en", 64'(sensors_en_o), 64'(5'h0));
        chk("rst_done", 64'(scan_done_o), 64'(1'b0));
        chk("rst_busy", 64'(busy_o), 64'(1'b0));
        chk("rst_req", 64'(sensor_req_o), 64'(1'b0));
        chk("rst_sel", 64'(sensor_sel_o), 64'(3'h0));
        rst_i = 1'b0;

        // All immediate acks, readings 20..24.
        for (int k = 0; k < NR; k++) begin
            dly[k] = 0;
            val[k] = 8'(20 + k);
        end
        run_scan(1'b0);

        // Sensor 2 silent.
        dly[2] = -1;
        run_scan(1'b0);

        // Sensor 0 answers on its final allowed cycle.
        for (int k = 0; k < NR; k++) begin
            dly[k] = 0;
            val[k] = 8'($urandom);
        end
        dly[0] = TMO - 1;
        run_scan(1'b0);

        // Start pulses and spurious acks throughout the scan.
        for (int k = 0; k < NR; k++) dly[k] = int'($urandom_range(0, 3));
        run_scan(1'b1);

        // Scan A then scan B with sensor 4 silent.
        for (int k = 0; k < NR; k++) begin
            dly[k] = 0;
            val[k] = 8'h30;
        end
        run_scan(1'b0);
        dly[4] = -1;
        run_scan(1'b0);

        // Reset while polling sensor 3, with start_i also high.
        for (int k = 0; k < NR; k++) dly[k] = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        guard   = 0;
        while (!(sensor_req_o === 1'b1 && sensor_sel_o == 3'd3) && guard < 100) begin
            sensor_ack_i  = (sensor_req_o === 1'b1);
            sensor_data_i = 8'($urandom);
            @(negedge clk_i);
            guard++;
        end
        chk("reach_sensor3", 64'(guard < 100), 64'(1'b1));
        rst_i        = 1'b1;
        start_i      = 1'b1;
        sensor_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;
        chk("mid_rst_req", 64'(sensor_req_o), 64'(1'b0));
        chk("mid_rst_busy", 64'(busy_o), 64'(1'b0));
        chk("mid_rst_data", 64'(sensors_data_o), 64'(40'h0));
        chk("mid_rst_en", 64'(sensors_en_o), 64'(5'h0));
        stray_done = 1'b0;
        repeat (12) begin
            if (scan_done_o !== 1'b0 || busy_o !== 1'b0) stray_done = 1'b1;
            @(negedge clk_i);
        end
        chk("no_done_after_rst", 64'(stray_done), 64'(1'b0));
        last_data = '0;
        last_en   = '0;

        for (int k = 0; k < NR; k++) val[k] = 8'($urandom);
        run_scan(1'b0);

        // Randomized scans, delays straddling the timeout boundary.
        repeat (12) begin
            for (int k = 0; k < NR; k++) begin
                dly[k] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
                val[k] = 8'($urandom);
            end
            run_scan(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
